// File: rtl/uart_rx_ovs.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, 16x oversampling with 3-sample majority vote.
// Optional parity bit when UART_RX_PARITY_EN is defined; one-entry ready/valid output buffer.
module uart_rx_ovs #(
   parameter int CLK_FREQ_HZ = 25000000,
   parameter int BAUD_RATE   = 115200,
   parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD  = 1'b0
`endif
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       parity_err_o
);

   localparam int OVS_DIV = CLK_FREQ_HZ / (BAUD_RATE * 16);
   localparam int OVS_W   = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
   localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS_DIV - 1);

   localparam logic [3:0] TICK_S0  = 4'd7;
   localparam logic [3:0] TICK_S1  = 4'd8;
   localparam logic [3:0] TICK_DEC = 4'd9;
   localparam logic [3:0] TICK_END = 4'd15;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
      ,
      S_PARITY = 3'd4
`endif
   } state_e;

   // ------------------------------------------------------------------
   // Input synchroniser and edge history
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_prev_q;
   logic                   rx_s;

   assign rx_s = sync_q[SYNC_STAGES-1];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rx_prev_q <= rx_s;
      end
   end

   // ------------------------------------------------------------------
   // Receive datapath and FSM state
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [OVS_W-1:0] ovs_q, ovs_d;
   logic [3:0]       tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       samp_q, samp_d;
   logic [7:0]       shreg_q, shreg_d;

   logic tick;
   logic decide;
   logic last_tick;
   logic bit_val;
   logic fall;
   logic deliver;
   logic frame_err_d;

`ifdef UART_RX_PARITY_EN
   logic par_mis_q, par_mis_d;
   logic parity_err_q, parity_err_d;
   logic par_exp;

   assign par_exp = (^shreg_q) ^ PARITY_ODD;
`endif

   assign tick      = (ovs_q == OVS_LAST);
   assign decide    = tick && (tick_q == TICK_DEC);
   assign last_tick = tick && (tick_q == TICK_END);
   assign fall      = rx_prev_q && !rx_s;
   // Two stored samples (ticks 7, 8) vote with the live sample at tick 9.
   assign bit_val   = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      ovs_d       = ovs_q;
      tick_d      = tick_q;
      bit_d       = bit_q;
      samp_d      = samp_q;
      shreg_d     = shreg_q;
      deliver     = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_d    = par_mis_q;
      parity_err_d = 1'b0;
`endif

      // Idle holds the phase counters at zero, so START entry phase-locks to the edge.
      if (state_q == S_IDLE) begin
         ovs_d  = '0;
         tick_d = '0;
      end else begin
         ovs_d = tick ? '0 : ovs_q + OVS_W'(1);
         if (tick) begin
            tick_d = tick_q + 4'd1;
         end
         if (tick && (tick_q == TICK_S0)) begin
            samp_d[1] = rx_s;
         end
         if (tick && (tick_q == TICK_S1)) begin
            samp_d[0] = rx_s;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (fall) begin
               state_d = S_START;
               bit_d   = '0;
`ifdef UART_RX_PARITY_EN
               par_mis_d = 1'b0;
`endif
            end
         end

         S_START: begin
            if (decide && bit_val) begin
               state_d = S_IDLE;
            end else if (last_tick) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end

         S_DATA: begin
            if (decide) begin
               shreg_d = {bit_val, shreg_q[7:1]};
            end
            if (last_tick) begin
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (decide) begin
               par_mis_d = (bit_val != par_exp);
            end
            if (last_tick) begin
               state_d = S_STOP;
            end
         end
`endif

         S_STOP: begin
            // Leave at the stop decision so a short stop bit cannot swallow the next start edge.
            if (decide) begin
               state_d = S_IDLE;
               if (!bit_val) begin
                  frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_mis_q) begin
                  parity_err_d = 1'b1;
`endif
               end else begin
                  deliver = 1'b1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         state_q <= S_IDLE;
         ovs_q   <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         samp_q  <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         ovs_q   <= ovs_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         samp_q  <= samp_d;
         shreg_q <= shreg_d;
      end
   end

   // ------------------------------------------------------------------
   // One-entry output buffer and error pulses
   // ------------------------------------------------------------------
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q;

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (deliver) begin
         if (!valid_q || ready_i) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         data_q      <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         data_q      <= data_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         par_mis_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_mis_q    <= par_mis_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign overrun_o   = overrun_q;
   assign frame_err_o = frame_err_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Self-checking bench for uart_rx_ovs: directed scenarios plus randomized frames
// checked against a frame-level reference model (expected byte queue and error counts).
module tb_uart_rx_ovs;

   localparam int CLK_FREQ_HZ = 18432000;
   localparam int BAUD_RATE   = 115200;
   localparam int SYNC_STAGES = 2;
   localparam int BIT_CLKS    = CLK_FREQ_HZ / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS  = 11;
   localparam bit PARITY_ODD  = 1'b0;
`else
   localparam int FRAME_BITS  = 10;
`endif
   // Stop decision lands at the end of oversample tick 9 of the stop bit, plus synchroniser delay.
   localparam int EXP_LAT     = (FRAME_BITS - 1) * BIT_CLKS + (BIT_CLKS * 10) / 16 + SYNC_STAGES;
   localparam int LAT_TOL     = 4;

   logic       clk_i   = 1'b0;
   logic       arst_i  = 1'b0;
   logic       rx_i    = 1'b1;
   logic       ready_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o;
   logic       busy_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       parity_err_o;

   uart_rx_ovs #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .BAUD_RATE  (BAUD_RATE),
      .SYNC_STAGES(SYNC_STAGES)
`ifdef UART_RX_PARITY_EN
      ,
      .PARITY_ODD (PARITY_ODD)
`endif
   ) dut (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .parity_err_o(parity_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Observation of the output side, sampled on the falling edge.
   logic [7:0] acc_q[$];
   logic [7:0] last_acc      = 8'h00;
   int         n_valid_rise  = 0;
   int         last_rise_cyc = 0;
   logic       busy_at_rise  = 1'b0;
   int         n_ferr        = 0;
   int         n_ovr         = 0;
   int         n_perr        = 0;
   int         n_busy_rise   = 0;
   logic       wide_pulse    = 1'b0;
   logic       err_with_rise = 1'b0;
   logic       valid_prev    = 1'b0;
   logic       busy_prev     = 1'b0;
   logic       fe_prev       = 1'b0;
   logic       ov_prev       = 1'b0;
   logic       pe_prev       = 1'b0;

   always @(negedge clk_i) begin
      if (arst_i) begin
         if (valid_o && ready_i) begin
            acc_q.push_back(data_o);
            last_acc = data_o;
         end
         if (valid_o && !valid_prev) begin
            n_valid_rise++;
            last_rise_cyc = cyc;
            busy_at_rise  = busy_o;
            if (frame_err_o || parity_err_o) err_with_rise = 1'b1;
         end
         if (frame_err_o)  n_ferr++;
         if (overrun_o)    n_ovr++;
         if (parity_err_o) n_perr++;
         if ((frame_err_o && fe_prev) || (overrun_o && ov_prev) || (parity_err_o && pe_prev))
            wide_pulse = 1'b1;
         if (busy_o && !busy_prev) n_busy_rise++;
      end
      valid_prev = arst_i & valid_o;
      busy_prev  = arst_i & busy_o;
      fe_prev    = arst_i & frame_err_o;
      ov_prev    = arst_i & overrun_o;
      pe_prev    = arst_i & parity_err_o;
   end

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: run exceeded 200000 clocks");
      $fatal(1, "timeout");
   end

   // Line image of one frame, LSB at index 0 (start bit first).
   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
      return {stop_bit, (^d) ^ PARITY_ODD, d, 1'b0};
`else
      return {1'b1, stop_bit, d, 1'b0};
`endif
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int tail, output int start_cyc);
      @(posedge clk_i);
      #1;
      start_cyc = cyc;
      for (int i = 0; i < FRAME_BITS; i++) begin
         rx_i = bits[i];
         repeat (BIT_CLKS) @(posedge clk_i);
         #1;
      end
      if (tail > 0) begin
         repeat (tail) @(posedge clk_i);
         #1;
      end
      rx_i = 1'b1;
   endtask

   task automatic test_reset();
      arst_i  = 1'b0;
      rx_i    = 1'b1;
      ready_i = 1'b1;
      repeat (4) @(negedge clk_i);
      n_checks++;
      if (data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", data_o);
      else n_pass++;
      n_checks++;
      if ({valid_o, busy_o, frame_err_o, overrun_o, parity_err_o} !== 5'b0)
         $display("FAIL reset_flags: got %b want 00000",
                  {valid_o, busy_o, frame_err_o, overrun_o, parity_err_o});
      else n_pass++;
      @(posedge clk_i);
      #1 arst_i = 1'b1;
      repeat (20) @(negedge clk_i);
      n_checks++;
      if ({valid_o, busy_o} !== 2'b00) $display("FAIL post_reset_idle: got %b want 00", {valid_o, busy_o});
      else n_pass++;
   endtask

   task automatic test_basic();
      int s;
      int r0 = n_valid_rise;
      int e0 = n_ferr + n_ovr + n_perr;
      send_bits(frame_bits(8'h55, 1'b1), 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if (n_valid_rise !== r0 + 1) $display("FAIL basic_valid_count: got %0d want %0d", n_valid_rise, r0 + 1);
      else n_pass++;
      n_checks++;
      if (last_acc !== 8'h55) $display("FAIL basic_data: got %h want 55", last_acc);
      else n_pass++;
      n_checks++;
      if ((last_rise_cyc - s) < EXP_LAT - LAT_TOL || (last_rise_cyc - s) > EXP_LAT + LAT_TOL)
         $display("FAIL basic_latency: got %0d want %0d+-%0d", last_rise_cyc - s, EXP_LAT, LAT_TOL);
      else n_pass++;
      n_checks++;
      if (busy_at_rise !== 1'b0) $display("FAIL basic_busy_at_valid: got %b want 0", busy_at_rise);
      else n_pass++;
      n_checks++;
      if (n_ferr + n_ovr + n_perr !== e0) $display("FAIL basic_no_err: got %0d want %0d", n_ferr + n_ovr + n_perr, e0);
      else n_pass++;
   endtask

   task automatic test_false_start();
      int b0 = n_busy_rise;
      int r0 = n_valid_rise;
      int e0 = n_ferr + n_ovr + n_perr;
      @(posedge clk_i);
      #1 rx_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rx_i = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk_i);
      n_checks++;
      if (n_busy_rise !== b0 + 1) $display("FAIL glitch_busy_pulse: got %0d want %0d", n_busy_rise, b0 + 1);
      else n_pass++;
      n_checks++;
      if ({n_valid_rise, busy_o} !== {r0, 1'b0})
         $display("FAIL glitch_no_output: got rises=%0d busy=%b want rises=%0d busy=0", n_valid_rise, busy_o, r0);
      else n_pass++;
      n_checks++;
      if (n_ferr + n_ovr + n_perr !== e0) $display("FAIL glitch_no_err: got %0d want %0d", n_ferr + n_ovr + n_perr, e0);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      int s;
      int f0 = n_ferr;
      int r0 = n_valid_rise;
      int b0 = n_busy_rise;
      // Stop bit low, and the line stays low three more bit times.
      send_bits(frame_bits(8'h3C, 1'b0), 3 * BIT_CLKS, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if (n_ferr !== f0 + 1) $display("FAIL ferr_pulse: got %0d want %0d", n_ferr, f0 + 1);
      else n_pass++;
      n_checks++;
      if (n_valid_rise !== r0) $display("FAIL ferr_no_valid: got %0d want %0d", n_valid_rise, r0);
      else n_pass++;
      n_checks++;
      if (n_busy_rise !== b0 + 1) $display("FAIL ferr_no_retrigger: got %0d want %0d", n_busy_rise, b0 + 1);
      else n_pass++;
      send_bits(frame_bits(8'h81, 1'b1), 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if ({n_valid_rise, last_acc} !== {r0 + 1, 8'h81})
         $display("FAIL ferr_recover: got rises=%0d data=%h want rises=%0d data=81", n_valid_rise, last_acc, r0 + 1);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int s;
      int o0 = n_ovr;
      int a0 = acc_q.size();
      ready_i = 1'b0;
      send_bits(frame_bits(8'h11, 1'b1), 0, s);
      send_bits(frame_bits(8'h22, 1'b1), 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if ({valid_o, data_o} !== {1'b1, 8'h11})
         $display("FAIL ovr_hold: got valid=%b data=%h want valid=1 data=11", valid_o, data_o);
      else n_pass++;
      n_checks++;
      if (n_ovr !== o0 + 1) $display("FAIL ovr_pulse: got %0d want %0d", n_ovr, o0 + 1);
      else n_pass++;
      n_checks++;
      if (acc_q.size() !== a0) $display("FAIL ovr_no_accept: got %0d want %0d", acc_q.size(), a0);
      else n_pass++;
      @(posedge clk_i);
      #1 ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL ovr_drain_valid: got %b want 0", valid_o);
      else n_pass++;
      n_checks++;
      if ({acc_q.size(), last_acc} !== {a0 + 1, 8'h11})
         $display("FAIL ovr_drain_data: got n=%0d data=%h want n=%0d data=11", acc_q.size(), last_acc, a0 + 1);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int s;
      int r0;
      logic [10:0] fb = frame_bits(8'hA5, 1'b1);
      @(posedge clk_i);
      #1 rx_i = 1'b0;
      repeat (BIT_CLKS) @(posedge clk_i);
      #1;
      for (int i = 1; i <= 4; i++) begin
         rx_i = fb[i];
         repeat (BIT_CLKS) @(posedge clk_i);
         #1;
      end
      rx_i = fb[5];
      repeat (BIT_CLKS / 2) @(posedge clk_i);
      #1;
      n_checks++;
      if (busy_o !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy_o);
      else n_pass++;
      arst_i = 1'b0;
      rx_i   = 1'b1;
      #2;
      n_checks++;
      if ({data_o, valid_o, busy_o, frame_err_o, overrun_o, parity_err_o} !== 13'b0)
         $display("FAIL midrst_outputs: got data=%h flags=%b want all 0", data_o,
                  {valid_o, busy_o, frame_err_o, overrun_o, parity_err_o});
      else n_pass++;
      repeat (5) @(posedge clk_i);
      #1 arst_i = 1'b1;
      repeat (2 * BIT_CLKS) @(posedge clk_i);
      r0 = n_valid_rise;
      send_bits(frame_bits(8'hC3, 1'b1), 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if ({n_valid_rise, last_acc} !== {r0 + 1, 8'hC3})
         $display("FAIL midrst_recover: got rises=%0d data=%h want rises=%0d data=c3", n_valid_rise, last_acc, r0 + 1);
      else n_pass++;
   endtask

   task automatic test_random();
      int         s;
      logic [7:0] exp_q[$];
      int         exp_ferr = 0;
      int         a0 = acc_q.size();
      int         f0 = n_ferr;
      int         bad = 0;
      for (int k = 0; k < 12; k++) begin
         logic [7:0] d  = 8'($urandom_range(0, 255));
         logic       st = ($urandom_range(0, 4) != 0);
         if (st) exp_q.push_back(d);
         else exp_ferr++;
         send_bits(frame_bits(d, st), 0, s);
         repeat ($urandom_range(0, 40)) @(posedge clk_i);
      end
      repeat (4) @(negedge clk_i);
      n_checks++;
      if (acc_q.size() - a0 !== exp_q.size())
         $display("FAIL rand_count: got %0d want %0d", acc_q.size() - a0, exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size() && a0 + k < acc_q.size(); k++)
         if (acc_q[a0 + k] !== exp_q[k]) bad++;
      n_checks++;
      if (bad !== 0) $display("FAIL rand_data: got %0d mismatching bytes want 0", bad);
      else n_pass++;
      n_checks++;
      if (n_ferr - f0 !== exp_ferr) $display("FAIL rand_ferr: got %0d want %0d", n_ferr - f0, exp_ferr);
      else n_pass++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int s;
      int p0 = n_perr;
      int r0 = n_valid_rise;
      // 0x07 has three ones; even parity needs a 1, so a 0 is a mismatch.
      send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if ({n_perr, n_valid_rise} !== {p0 + 1, r0})
         $display("FAIL par_bad: got perr=%0d rises=%0d want perr=%0d rises=%0d", n_perr, n_valid_rise, p0 + 1, r0);
      else n_pass++;
      send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 0, s);
      repeat (4) @(negedge clk_i);
      n_checks++;
      if ({n_perr, last_acc} !== {p0 + 1, 8'h07})
         $display("FAIL par_good: got perr=%0d data=%h want perr=%0d data=07", n_perr, last_acc, p0 + 1);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_reset_mid();
      test_random();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      n_checks++;
      if ({wide_pulse, err_with_rise} !== 2'b00)
         $display("FAIL pulse_shape: got wide=%b err_with_valid=%b want 00", wide_pulse, err_with_rise);
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
